dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port data memory between the pipeline's MEM stage and an external host port used for program loading and debug. It owns the memory-side address, data and control lines, and stalls the CPU while a host access is in flight. It sits between the EX_MEM register outputs and the data memory. An optional starvation guard bounds how long the host can wait.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 8, number of contended cycles before the host is forced in (used only with the guard enabled)

Ports:
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `CpuReq` in 1: MEM stage wants memory this cycle (MemRead | MemWrite).
- `CpuWrite`, `CpuByte`, `CpuHalf` in 1 each: CPU access type.
- `CpuAddr` in ADDR_W; `CpuWData` in DATA_W.
- `CpuStall` out 1: CPU must hold its MEM-stage access and freeze the pipeline.
- `CpuRData` out DATA_W: combinational pass-through of `MemRData`.
- `HostReq` in 1; `HostWrite` in 1; `HostAddr` in ADDR_W; `HostWData` in DATA_W: host access, word only.
- `HostAck` out 1: one-cycle pulse, the host access has completed.
- `HostRData` out DATA_W: registered host read data, valid with `HostAck`.
- `MemAddr` out ADDR_W; `MemWData` out DATA_W; `MemWrite`, `MemRead`, `MemByte`, `MemHalf` out 1 each: drive the data memory.
- `MemRData` in DATA_W: memory read data (combinational read).

## Operation
- FSM states:
  - CPU_OWN (reset state): memory mux selects CPU; `CpuStall`=0.
  - HOST_ACC: memory mux selects host; `MemByte`=`MemHalf`=0; `MemRead`=!`HostWrite`; `CpuStall`=`CpuReq`.
  - HOST_ACK: mux selects CPU; `CpuStall`=0; `HostAck`=1.
- CPU_OWN → HOST_ACC when `HostReq` && (!`CpuReq` || starve_hit). Otherwise the FSM stays in CPU_OWN.
  - The CPU access in the deciding cycle completes normally.
- HOST_ACC → HOST_ACK unconditionally.
  - `HostRData` <= `MemRData` at this edge if it was a read; otherwise it keeps its previous value.
- HOST_ACK → CPU_OWN unconditionally. The host is not granted in HOST_ACK.
- A host request is committed once in HOST_ACC. Dropping `HostReq` mid-access does not cancel the access or the ack.
- The host must hold `HostReq` and its fields until the grant edge.
- `HostReq` high in HOST_ACK is treated as a new request, evaluated in the next CPU_OWN cycle.
- With `Reset` high:
  - `MemWrite`=`MemRead`=0, regardless of state or inputs.
  - At the edge: state <= CPU_OWN, `HostAck` <= 0, `HostRData` <= 0, counter <= 0.

## Timing
- Reset values: `CpuStall`=0, `HostAck`=0, `HostRData`=0, `MemWrite`=0, `MemRead`=0.
- Host latency with the CPU idle:
  - `HostReq` sampled high at edge N → HOST_ACC during cycle N+1 → `HostAck` during cycle N+2.
  - Back-to-back host throughput: one access per 3 cycles.
- CPU stall: at most 1 cycle per host access, and only while in HOST_ACC.
- Memory write occurs at the rising edge that ends the cycle driving `MemWrite`. This matches existing DataMemory timing.
- CPU mux path (`Cpu*` → `Mem*`, `MemRData` → `CpuRData`) is combinational. No added latency for the CPU.

## Configuration
- `DMEM_ARB_STARVE_EN` defined:
  - A counter increments each CPU_OWN cycle with `HostReq` && `CpuReq`.
  - starve_hit = (count == `STARVE_LIMIT`-1) while contended.
  - The counter clears on a host grant and on reset.
  - Width is $clog2(`STARVE_LIMIT`+1).
- Not defined:
  - starve_hit is tied to 0 and no counter is instantiated.
  - The CPU has strict priority; the host waits until `CpuReq`=0.

## Structure
- Package `dmem_arb_pkg`:
  - state encoding: CPU_OWN=2'b00, HOST_ACC=2'b01, HOST_ACK=2'b10; 2'b11 recovers to CPU_OWN.
  - default `STARVE_LIMIT`.
- Sub-module `dmem_arb_starve_counter` (guard counter plus compare), instantiated only under `DMEM_ARB_STARVE_EN`.
- Top: FSM, memory mux, host read register.

## Test plan
- Reset: hold `Reset` 2 cycles with `CpuReq`=1, `CpuWrite`=1, `HostReq`=1.
  - Expect `MemWrite`=0, `MemRead`=0, `HostAck`=0, `HostRData`=0, `CpuStall`=0.
  - One cycle after release: state CPU_OWN.
- Host write, then read, CPU idle:
  - Write 0xDEADBEEF to 0x40: `MemWrite`=1 with `MemAddr`=0x40 in HOST_ACC; `HostAck` 1 cycle later.
  - Read 0x40: `HostRData`=0xDEADBEEF with `HostAck`.
- CPU priority: `CpuReq`=`HostReq`=1 for 5 cycles, `STARVE_LIMIT`=8.
  - No grant, `CpuStall`=0 throughout, `MemAddr` follows `CpuAddr`.
- Starvation, `DMEM_ARB_STARVE_EN` defined, limit 8: both requests held continuously.
  - Expect HOST_ACC after the 8th contended cycle, with `CpuStall`=1 for exactly 1 cycle.
  - Next host grant follows 8 contended CPU_OWN cycles after HOST_ACK.
  - With the macro undefined: no grant ever.
- Back-to-back: `HostReq` held high, `CpuReq`=0 for 12 cycles.
  - `HostAck` pulses every 3 cycles, 4 pulses total.
- Reset mid-operation: assert `Reset` during HOST_ACC of a host write.
  - `MemWrite`=0 in that cycle, no `HostAck` follows, state CPU_OWN.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// FSM state encoding and the default starvation limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'b00,
    HOST_ACC = 2'b01,
    HOST_ACK = 2'b10
  } state_t;

  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_counter.sv
// Starvation guard: counts contended CPU_OWN cycles.
// Flags a hit on the LIMIT-th consecutive contended cycle.
module dmem_arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_hit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] HIT_VAL = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_hit = i_inc && (r_cnt == HIT_VAL);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the MEM stage and a host port.
// Optional starvation guard: define DMEM_ARB_STARVE_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWrite,
  input  logic              CpuByte,
  input  logic              CpuHalf,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuStall,
  output logic [DATA_W-1:0] CpuRData,
  input  logic              HostReq,
  input  logic              HostWrite,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWData,
  output logic              HostAck,
  output logic [DATA_W-1:0] HostRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              MemByte,
  output logic              MemHalf,
  input  logic [DATA_W-1:0] MemRData
);

  state_t            r_state;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic [ADDR_W-1:0] r_h_addr;
  logic [DATA_W-1:0] r_h_wdata;
  logic              r_h_write;

  logic w_own;
  logic w_host_sel;
  logic w_contend;
  logic w_starve_hit;
  logic w_grant;

  assign w_own      = (r_state == CPU_OWN);
  assign w_host_sel = (r_state == HOST_ACC);
  assign w_contend  = w_own && HostReq && CpuReq;
  assign w_grant    = w_own && HostReq && (!CpuReq || w_starve_hit);

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_inc (w_contend),
    .i_clr (w_grant),
    .o_hit (w_starve_hit)
  );
`else
  logic w_unused_guard;
  assign w_unused_guard = w_contend & (STARVE_LIMIT > 0);
  assign w_starve_hit   = 1'b0;
`endif

  // Host fields are latched at the grant edge so the host may move on.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= CPU_OWN;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
      r_h_addr     <= '0;
      r_h_wdata    <= '0;
      r_h_write    <= 1'b0;
    end else begin
      case (r_state)
        CPU_OWN: begin
          r_host_ack <= 1'b0;
          if (w_grant) begin
            r_state   <= HOST_ACC;
            r_h_addr  <= HostAddr;
            r_h_wdata <= HostWData;
            r_h_write <= HostWrite;
          end
        end
        HOST_ACC: begin
          r_state    <= HOST_ACK;
          r_host_ack <= 1'b1;
          if (!r_h_write) begin
            r_host_rdata <= MemRData;
          end
        end
        HOST_ACK: begin
          r_state    <= CPU_OWN;
          r_host_ack <= 1'b0;
        end
        default: begin
          r_state    <= CPU_OWN;
          r_host_ack <= 1'b0;
        end
      endcase
    end
  end

  assign HostAck   = r_host_ack;
  assign HostRData = r_host_rdata;
  assign CpuRData  = MemRData;
  assign CpuStall  = !Reset && w_host_sel && CpuReq;

  assign MemAddr  = w_host_sel ? r_h_addr  : CpuAddr;
  assign MemWData = w_host_sel ? r_h_wdata : CpuWData;
  assign MemByte  = w_host_sel ? 1'b0 : CpuByte;
  assign MemHalf  = w_host_sel ? 1'b0 : CpuHalf;

  assign MemWrite = !Reset &&
    (w_host_sel ? r_h_write : (CpuReq && CpuWrite));
  assign MemRead  = !Reset &&
    (w_host_sel ? !r_h_write : (CpuReq && !CpuWrite));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a transaction-level model.
// Starvation expectations follow DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;

  localparam int LIMIT = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWrite, CpuByte, CpuHalf;
  logic [31:0] CpuAddr, CpuWData;
  logic        CpuStall;
  logic [31:0] CpuRData;
  logic        HostReq, HostWrite;
  logic [31:0] HostAddr, HostWData;
  logic        HostAck;
  logic [31:0] HostRData;
  logic [31:0] MemAddr, MemWData;
  logic        MemWrite, MemRead, MemByte, MemHalf;
  logic [31:0] MemRData;

  dmem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CpuReq    (CpuReq),
    .CpuWrite  (CpuWrite),
    .CpuByte   (CpuByte),
    .CpuHalf   (CpuHalf),
    .CpuAddr   (CpuAddr),
    .CpuWData  (CpuWData),
    .CpuStall  (CpuStall),
    .CpuRData  (CpuRData),
    .HostReq   (HostReq),
    .HostWrite (HostWrite),
    .HostAddr  (HostAddr),
    .HostWData (HostWData),
    .HostAck   (HostAck),
    .HostRData (HostRData),
    .MemAddr   (MemAddr),
    .MemWData  (MemWData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .MemByte   (MemByte),
    .MemHalf   (MemHalf),
    .MemRData  (MemRData)
  );

  always #5 Clk = ~Clk;

  // Memory behind the arbiter: combinational read, write at the edge.
  logic [31:0] mem [64];
  assign MemRData = mem[MemAddr[7:2]];
  always @(posedge Clk) begin
    if (MemWrite) mem[MemAddr[7:2]] <= MemWData;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: host transaction progress (0 idle, 1 on memory, 2 acked),
  // contended-cycle run length, the host's latched request and a
  // reference copy of memory contents.
  int          m_phase;
  int          m_run;
  logic [31:0] m_haddr, m_hwdata, m_rdata;
  bit          m_hwrite;
  logic [31:0] refm [64];
  bit          starve_en;
  bit          last_stall;
  int          acks;

  task automatic model_edge();
    bit contended, forced;
    if (Reset) begin
      m_phase = 0;
      m_run   = 0;
      m_rdata = 0;
      return;
    end
    if (m_phase == 1) begin
      if (m_hwrite) refm[m_haddr[7:2]] = m_hwdata;
      else          m_rdata = refm[m_haddr[7:2]];
      m_phase = 2;
      return;
    end
    if (CpuReq && CpuWrite) refm[CpuAddr[7:2]] = CpuWData;
    if (m_phase == 2) begin
      m_phase = 0;
      return;
    end
    contended = HostReq && CpuReq;
    forced    = starve_en && contended && (m_run + 1 >= LIMIT);
    if (HostReq && (!CpuReq || forced)) begin
      m_phase  = 1;
      m_run    = 0;
      m_haddr  = HostAddr;
      m_hwdata = HostWData;
      m_hwrite = HostWrite;
    end else if (contended) begin
      m_run++;
    end
  endtask

  task automatic cyc();
    bit          hs;
    logic [31:0] ea;
    @(negedge Clk);
    hs = (m_phase == 1);
    ea = hs ? m_haddr : CpuAddr;
    chk("MemAddr", MemAddr, ea);
    chk("MemWData", MemWData, hs ? m_hwdata : CpuWData);
    chk("MemWrite", MemWrite,
        !Reset && (hs ? m_hwrite : (CpuReq && CpuWrite)));
    chk("MemRead", MemRead,
        !Reset && (hs ? !m_hwrite : (CpuReq && !CpuWrite)));
    chk("MemByte", MemByte, hs ? 1'b0 : CpuByte);
    chk("MemHalf", MemHalf, hs ? 1'b0 : CpuHalf);
    chk("CpuStall", CpuStall, !Reset && hs && CpuReq);
    chk("HostAck", HostAck, m_phase == 2);
    chk("HostRData", HostRData, m_rdata);
    chk("CpuRData", CpuRData, refm[ea[7:2]]);
    last_stall = (CpuStall === 1'b1);
    if (HostAck === 1'b1) acks++;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    CpuReq = 0; CpuWrite = 0; CpuByte = 0; CpuHalf = 0;
    CpuAddr = 0; CpuWData = 0;
    HostReq = 0; HostWrite = 0; HostAddr = 0; HostWData = 0;
  endtask

  task automatic do_reset();
    Reset = 1;
    idle_inputs();
    cyc();
    Reset = 0;
  endtask

  int          stalls, first;
  bit          h_pend;
  int          p;
  logic [31:0] keep;

  initial begin
`ifdef DMEM_ARB_STARVE_EN
    starve_en = 1;
`else
    starve_en = 0;
`endif
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 0;
      refm[i] = 0;
    end
    m_phase = 0; m_run = 0; m_rdata = 0;
    m_haddr = 0; m_hwdata = 0; m_hwrite = 0;
    acks = 0;
    Reset = 1;
    idle_inputs();
    @(posedge Clk);
    #1;

    // Reset held two cycles with both sides requesting.
    CpuReq = 1; CpuWrite = 1; HostReq = 1; HostWrite = 1;
    CpuAddr = 32'h10; HostAddr = 32'h20;
    cyc();
    cyc();
    chk("rst_ack", HostAck, 1'b0);
    chk("rst_rdata", HostRData, 32'h0);
    Reset = 0;
    idle_inputs();

    // Host write then read with CPU idle.
    HostReq = 1; HostWrite = 1;
    HostAddr = 32'h40; HostWData = 32'hDEADBEEF;
    cyc();
    HostReq = 0;
    chk("wr_memwrite", MemWrite, 1'b1);
    chk("wr_memaddr", MemAddr, 32'h40);
    cyc();
    chk("wr_ack", HostAck, 1'b1);
    cyc();
    HostReq = 1; HostWrite = 0; HostAddr = 32'h40;
    cyc();
    HostReq = 0;
    cyc();
    chk("rd_ack", HostAck, 1'b1);
    chk("rd_data", HostRData, 32'hDEADBEEF);
    cyc();

    // CPU priority over a short contended window.
    do_reset();
    stalls = 0;
    CpuReq = 1; HostReq = 1; HostWrite = 0; HostAddr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      CpuAddr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      cyc();
      stalls += int'(last_stall);
    end
    chk("prio_stalls", stalls, 0);

    // Sustained contention: guard forces the host in periodically.
    do_reset();
    stalls = 0; first = -1;
    CpuReq = 1; CpuWrite = 0; HostReq = 1; HostWrite = 0;
    HostAddr = 32'hC;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (last_stall && first < 0) first = i;
      stalls += int'(last_stall);
    end
    chk("starve_stalls", stalls, starve_en ? 2 : 0);
    chk("starve_first", first, starve_en ? LIMIT : -1);

    // Back-to-back host accesses.
    do_reset();
    acks = 0;
    HostReq = 1; HostWrite = 0; HostAddr = 32'h40;
    for (int i = 0; i < 12; i++) cyc();
    chk("b2b_acks", acks, 4);

    // Reset lands while a host write is on the memory.
    do_reset();
    keep = refm[5];
    HostReq = 1; HostWrite = 1;
    HostAddr = 32'h14; HostWData = ~keep;
    cyc();
    HostReq = 0;
    Reset = 1;
    cyc();
    Reset = 0;
    cyc();
    chk("rstmid_noack", HostAck, 1'b0);
    chk("rstmid_mem", mem[5], keep);
    cyc();

    // Randomized traffic with the host obeying the hold rule.
    do_reset();
    h_pend = 0;
    for (int i = 0; i < 600; i++) begin
      Reset    = ($urandom_range(0, 59) == 0);
      CpuReq   = 1'($urandom_range(0, 1));
      CpuWrite = 1'($urandom_range(0, 1));
      CpuByte  = 1'($urandom_range(0, 1));
      CpuHalf  = 1'($urandom_range(0, 1));
      CpuAddr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      CpuWData = $urandom;
      if (!h_pend) begin
        HostReq   = ($urandom_range(0, 2) == 0);
        HostWrite = 1'($urandom_range(0, 1));
        HostAddr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        HostWData = $urandom;
        h_pend    = HostReq;
      end
      p = m_phase;
      cyc();
      if (p == 0 && m_phase == 1) h_pend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
